// File: rtl/tile_object_map.sv
// Tile occupancy store: one object code per screen tile, two registered read ports,
// one write port, a clear sweep and a delayed, collision-safe plate respawn.
module tile_object_map #(
    parameter int NUM_TILES     = 120,
    parameter int IDX_W         = 7,
    parameter int SPR_W         = 3,
    parameter int PLATE_SPR     = 2,
    parameter int INIT_TILE     = 50,
    parameter int PLATE_HOME    = 60,
    parameter int RESPAWN_DELAY = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear_req,
    output logic             busy,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [SPR_W-1:0] wr_data,
    output logic             wr_rejected,
    input  logic [IDX_W-1:0] rd_a_idx,
    output logic [SPR_W-1:0] rd_a_data,
    input  logic [IDX_W-1:0] rd_b_idx,
    output logic [SPR_W-1:0] rd_b_data,
    input  logic             respawn_req,
    output logic             respawn_pending,
    output logic             respawn_done
);

    // state  | meaning
    // IDLE   | normal operation, reads/writes/respawn allowed
    // SWEEP  | zeroing tile sweep_idx, one tile per cycle
    // REINIT | restoring the plate at INIT_TILE, then back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        REINIT = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(RESPAWN_DELAY + 1);

    localparam logic [IDX_W:0]   NUM_TILES_L = (IDX_W + 1)'(NUM_TILES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TILES - 1);
    localparam logic [IDX_W-1:0] INIT_IDX    = IDX_W'(INIT_TILE);
    localparam logic [IDX_W-1:0] HOME_IDX    = IDX_W'(PLATE_HOME);
    localparam logic [SPR_W-1:0] PLATE_VAL   = SPR_W'(PLATE_SPR);
    localparam logic [CNT_W-1:0] DELAY_VAL   = CNT_W'(RESPAWN_DELAY);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] sweep_idx;
    logic [SPR_W-1:0] map [NUM_TILES];
    logic [CNT_W-1:0] resp_cnt;

    logic clear_go;
    logic wr_in_range;
    logic wr_ok;
    logic home_hit;
    logic resp_fire;

    assign busy        = (state_q != IDLE);
    assign clear_go    = (state_q == IDLE) && clear_req;
    assign wr_in_range = ({1'b0, wr_idx} < NUM_TILES_L);
    assign wr_ok       = wr_en && !busy && wr_in_range;
    assign home_hit    = wr_ok && (wr_idx == HOME_IDX);

    // A user write to the home tile wins over the respawn; an accepted clear cancels it.
    assign resp_fire = respawn_pending && (resp_cnt == '0) && !busy &&
                       (map[HOME_IDX] == '0) && !home_hit && !clear_go;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (sweep_idx == LAST_IDX) begin
                    state_d = REINIT;
                end
            end
            REINIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sweep_idx <= '0;
        end else if (state_q == SWEEP) begin
            sweep_idx <= sweep_idx + 1'b1;
        end else begin
            sweep_idx <= '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                map[i] <= (i == INIT_TILE) ? PLATE_VAL : '0;
            end
        end else begin
            case (state_q)
                SWEEP: begin
                    map[sweep_idx] <= '0;
                end
                REINIT: begin
                    map[INIT_IDX] <= PLATE_VAL;
                end
                default: begin
                    if (wr_ok) begin
                        map[wr_idx] <= wr_data;
                    end
                    if (resp_fire) begin
                        map[HOME_IDX] <= PLATE_VAL;
                    end
                end
            endcase
        end
    end

    // Read value as the map will look after this cycle's writes (write-first).
    function automatic logic [SPR_W-1:0] read_port(input logic [IDX_W-1:0] idx);
        if (busy || ({1'b0, idx} >= NUM_TILES_L)) begin
            return '0;
        end
        if (resp_fire && (idx == HOME_IDX)) begin
            return PLATE_VAL;
        end
        if (wr_ok && (idx == wr_idx)) begin
            return wr_data;
        end
        return map[idx];
    endfunction

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rd_a_data   <= '0;
            rd_b_data   <= '0;
            wr_rejected <= 1'b0;
        end else begin
            rd_a_data   <= read_port(rd_a_idx);
            rd_b_data   <= read_port(rd_b_idx);
            wr_rejected <= wr_en && !wr_ok;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            respawn_pending <= 1'b0;
            respawn_done    <= 1'b0;
            resp_cnt        <= '0;
        end else begin
            respawn_done <= resp_fire;
            if (clear_go) begin
                respawn_pending <= 1'b0;
                resp_cnt        <= '0;
            end else if (resp_fire) begin
                respawn_pending <= 1'b0;
            end else if (respawn_req && !respawn_pending) begin
                respawn_pending <= 1'b1;
                resp_cnt        <= DELAY_VAL;
            end else if (respawn_pending && (resp_cnt != '0)) begin
                resp_cnt <= resp_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_object_map.sv
// Bench for tile_object_map: vector table, hand-written corner sequences and
// random traffic against an edge-counting reference model.
module tb_tile_object_map;

    localparam int NT = 120;
    localparam int IW = 7;
    localparam int SW = 3;
    localparam int PS = 2;
    localparam int IT = 50;
    localparam int PH = 60;
    localparam int RD = 16;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          busy;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [SW-1:0] wr_data = '0;
    logic          wr_rejected;
    logic [IW-1:0] rd_a_idx = '0;
    logic [SW-1:0] rd_a_data;
    logic [IW-1:0] rd_b_idx = '0;
    logic [SW-1:0] rd_b_data;
    logic          respawn_req = 1'b0;
    logic          respawn_pending;
    logic          respawn_done;

    tile_object_map dut (
        .clk(clk), .Reset(Reset), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_rejected(wr_rejected),
        .rd_a_idx(rd_a_idx), .rd_a_data(rd_a_data), .rd_b_idx(rd_b_idx), .rd_b_data(rd_b_data),
        .respawn_req(respawn_req), .respawn_pending(respawn_pending), .respawn_done(respawn_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time-stamped events (edge numbers) instead of FSM state.
    int m_map [NT];
    int edge_n = 0;
    int sweep_start = -1000;
    bit m_pend = 0;
    int m_elig = 0;
    int e_rda = 0, e_rdb = 0, e_rej = 0, e_busy = 0, e_pend = 0, e_done = 0;

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) m_map[i] = (i == IT) ? PS : 0;
        sweep_start = -1000;
        m_pend = 0;
        e_rda = 0; e_rdb = 0; e_rej = 0; e_busy = 0; e_pend = 0; e_done = 0;
    endfunction

    function automatic bit busy_after(input int e);
        return (e >= sweep_start) && (e <= sweep_start + NT);
    endfunction

    function automatic void model_step();
        int prev;
        bit busy_now, clear_go, wr_ok, home_hit, fire;
        int wi, ai, bi;
        prev = edge_n;
        edge_n++;
        busy_now = busy_after(prev);
        clear_go = !busy_now && clear_req;
        wi = int'(wr_idx);
        ai = int'(rd_a_idx);
        bi = int'(rd_b_idx);
        wr_ok = wr_en && !busy_now && (wi < NT);
        home_hit = wr_ok && (wi == PH);
        fire = m_pend && (edge_n >= m_elig) && !busy_now && (m_map[PH] == 0) && !home_hit && !clear_go;
        if (busy_now) begin
            if (edge_n - sweep_start - 1 < NT) m_map[edge_n - sweep_start - 1] = 0;
            else m_map[IT] = PS;
        end else begin
            if (wr_ok) m_map[wi] = int'(wr_data);
            if (fire) m_map[PH] = PS;
        end
        e_rda = (busy_now || ai >= NT) ? 0 : m_map[ai];
        e_rdb = (busy_now || bi >= NT) ? 0 : m_map[bi];
        e_rej = wr_en && !wr_ok;
        if (clear_go) m_pend = 0;
        else if (fire) m_pend = 0;
        else if (respawn_req && !m_pend) begin
            m_pend = 1;
            m_elig = edge_n + RD + 1;
        end
        if (clear_go) sweep_start = edge_n;
        e_done = fire;
        e_pend = m_pend;
        e_busy = busy_after(edge_n);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("rd_a_data", int'(rd_a_data), e_rda);
        chk("rd_b_data", int'(rd_b_data), e_rdb);
        chk("wr_rejected", int'(wr_rejected), e_rej);
        chk("busy", int'(busy), e_busy);
        chk("respawn_pending", int'(respawn_pending), e_pend);
        chk("respawn_done", int'(respawn_done), e_done);
    endtask

    task automatic idle_inputs();
        clear_req = 0; wr_en = 0; respawn_req = 0;
    endtask

    typedef struct {
        bit wen; int wi; int wd; int ra; int rb; int ea; int eb; int erj;
    } vec_t;

    vec_t vecs [8];
    int n;
    bit saw_done;

    initial begin
        vecs[0] = '{0,   0, 0,  50,   0, 2, 0, 0};
        vecs[1] = '{1,   7, 5,   7,  50, 5, 2, 0};
        vecs[2] = '{1, 120, 3, 120,   7, 0, 5, 1};
        vecs[3] = '{1, 127, 1, 127,   0, 0, 0, 1};
        vecs[4] = '{1, 119, 6, 119, 119, 6, 6, 0};
        vecs[5] = '{1,   0, 7,   0, 119, 7, 6, 0};
        vecs[6] = '{0,   0, 0,   7, 120, 5, 0, 0};
        vecs[7] = '{1,  50, 0,  50,  60, 0, 0, 0};

        model_reset();
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_a", int'(rd_a_data), 0);
        chk("reset_pending", int'(respawn_pending), 0);
        chk("reset_done_rej", int'(respawn_done | wr_rejected), 0);
        @(negedge clk);
        Reset = 0;

        for (int i = 0; i < 8; i++) begin
            wr_en = vecs[i].wen; wr_idx = IW'(vecs[i].wi); wr_data = SW'(vecs[i].wd);
            rd_a_idx = IW'(vecs[i].ra); rd_b_idx = IW'(vecs[i].rb);
            tick();
            chk($sformatf("vec%0d_rd_a", i), int'(rd_a_data), vecs[i].ea);
            chk($sformatf("vec%0d_rd_b", i), int'(rd_b_data), vecs[i].eb);
            chk($sformatf("vec%0d_rej", i), int'(wr_rejected), vecs[i].erj);
            idle_inputs();
        end

        // clear sweep: busy length, rejected writes, post-clear image
        clear_req = 1;
        tick();
        clear_req = 0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            wr_en = 1; wr_idx = IW'($urandom_range(0, NT - 1)); wr_data = 3'd5;
            tick();
            chk("sweep_wr_rejected", int'(wr_rejected), 1);
        end
        chk("busy_cycles", n, NT + 1);
        idle_inputs();
        for (int i = 0; i < NT; i++) begin
            rd_a_idx = IW'(i); rd_b_idx = IW'(NT - 1 - i);
            tick();
            chk("post_clear_tile", int'(rd_a_data), (i == IT) ? PS : 0);
        end

        // respawn into an empty home tile
        respawn_req = 1;
        tick();
        respawn_req = 0;
        chk("respawn_pending_set", int'(respawn_pending), 1);
        n = 0;
        while (!respawn_done && n < 40) begin
            tick();
            n++;
        end
        chk("respawn_latency", n, RD + 1);
        rd_a_idx = IW'(PH);
        tick();
        chk("home_after_respawn", int'(rd_a_data), PS);

        // occupied home tile blocks the respawn until freed
        wr_en = 1; wr_idx = IW'(PH); wr_data = 3'd4;
        tick();
        wr_en = 0; respawn_req = 1;
        tick();
        respawn_req = 0;
        repeat (25) tick();
        chk("blocked_pending", int'(respawn_pending), 1);
        wr_en = 1; wr_idx = IW'(PH); wr_data = 3'd0;
        tick();
        chk("free_write_no_done", int'(respawn_done), 0);
        wr_en = 0;
        tick();
        chk("done_after_free", int'(respawn_done), 1);
        tick();
        chk("home_replated", int'(rd_a_data), PS);

        // clear cancels pending respawn
        respawn_req = 1;
        tick();
        respawn_req = 0;
        repeat (4) tick();
        clear_req = 1;
        tick();
        clear_req = 0;
        chk("clear_cancels_pending", int'(respawn_pending), 0);
        saw_done = 0;
        n = 0;
        while ((busy || n < 30) && n < 250) begin
            tick();
            if (respawn_done) saw_done = 1;
            n++;
        end
        chk("no_done_after_cancel", int'(saw_done), 0);

        // asynchronous reset in the middle of a sweep
        wr_en = 1; wr_idx = 7'd10; wr_data = 3'd3;
        tick();
        wr_en = 0; clear_req = 1;
        tick();
        clear_req = 0;
        repeat (30) tick();
        #2;
        Reset = 1;
        #1;
        model_reset();
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_rd", int'(rd_a_data), 0);
        @(negedge clk);
        Reset = 0;
        rd_a_idx = IW'(IT); rd_b_idx = 7'd10;
        tick();
        chk("reset_image_init", int'(rd_a_data), PS);
        chk("reset_image_tile10", int'(rd_b_data), 0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            wr_en = ($urandom_range(0, 2) == 0);
            wr_idx = ($urandom_range(0, 3) == 0) ? IW'(PH) : IW'($urandom_range(0, 127));
            wr_data = SW'($urandom_range(0, 7));
            rd_a_idx = ($urandom_range(0, 3) == 0) ? IW'(PH) : IW'($urandom_range(0, 127));
            rd_b_idx = IW'($urandom_range(0, 127));
            clear_req = ($urandom_range(0, 399) == 0);
            respawn_req = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
